// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus field positions, privilege encodings and cause codes.
// Also holds the read-modify-write helpers used by the CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MS_SIE  = 1;
  localparam int MS_MIE  = 3;
  localparam int MS_SPIE = 5;
  localparam int MS_MPIE = 7;
  localparam int MS_SPP  = 8;
  localparam int MS_MPP  = 11;
  localparam int MIX_MT  = 7;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_19AA;
  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;

  localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT   = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_U      = 32'h0000_0008;
  localparam logic [31:0] CAUSE_ECALL_S      = 32'h0000_0009;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'h0000_000B;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ  = 32'h8000_0007;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE,
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_op_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_v, logic [31:0] wdata);
    logic [31:0] r;
    case (op)
      CSR_OP_WRITE: r = wdata;
      CSR_OP_SET:   r = old_v | wdata;
      CSR_OP_CLEAR: r = old_v & ~wdata;
      default:      r = old_v;
    endcase
    return r;
  endfunction

  // MPP has no hypervisor level, so the reserved encoding 10 collapses to U.
  function automatic logic [31:0] mstatus_legalize(logic [31:0] v);
    logic [31:0] r;
    r = v & MSTATUS_MASK;
    if (r[MS_MPP+1:MS_MPP] == 2'b10) r[MS_MPP+1:MS_MPP] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running cycle counter; loading either half replaces it and skips
// that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [31:0] ld_data_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 64'd1;
    if (ld_lo_i)      count_d = {count_q[63:32], ld_data_i};
    else if (ld_hi_i) count_d = {ld_data_i, count_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine/supervisor CSR file with trap entry, mret/sret, timer interrupt
// request and a 64-bit cycle counter.
module csr_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_write,
  input  logic        csr_set,
  input  logic        csr_clear,
  output logic [31:0] csr_rdata,
  input  logic        csr_trap_take,
  input  logic [31:0] csr_trap_pc,
  input  logic [31:0] csr_cause,
  input  logic        csr_mret,
  input  logic        csr_sret,
  output logic [31:0] csr_trap_vector,
  output logic [31:0] csr_ret_addr,
  output logic [1:0]  current_priv,
  input  logic        irq_mtip,
  output logic        irq_req
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d, stvec_q, stvec_d;
  logic [31:0] mepc_q, mepc_d, sepc_q, sepc_d;
  logic [31:0] mscratch_q, mscratch_d, sscratch_q, sscratch_d;
  logic [31:0] mcause_q, mcause_d, scause_q, scause_d;
  logic        mtie_q, mtie_d;
  logic        mtip_q;
  priv_e       priv_q, priv_d;

  logic [63:0] mcycle;
  logic [31:0] rdata;
  logic [31:0] wr_val;
  csr_op_e     op;
  logic        csr_we;

  // Single read mux; also supplies the old value for set/clear.
  always_comb begin
    rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_SSTATUS:  rdata = mstatus_q & SSTATUS_MASK;
      CSR_MIE:      rdata[MIX_MT] = mtie_q;
      CSR_MIP:      rdata[MIX_MT] = mtip_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_STVEC:    rdata = stvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_SSCRATCH: rdata = sscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_SEPC:     rdata = sepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_SCAUSE:   rdata = scause_q;
      CSR_MCYCLE:   rdata = mcycle[31:0];
      CSR_MCYCLEH:  rdata = mcycle[63:32];
      CSR_MHARTID:  rdata = '0;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    op = CSR_OP_NONE;
    if (csr_write)      op = CSR_OP_WRITE;
    else if (csr_set)   op = CSR_OP_SET;
    else if (csr_clear) op = CSR_OP_CLEAR;
  end

  assign wr_val = csr_apply(op, rdata, csr_wdata);
  // Trap and returns outrank a CSR access issued in the same cycle.
  assign csr_we = !stall && (op != CSR_OP_NONE) && !csr_trap_take && !csr_mret && !csr_sret;

  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    stvec_d    = stvec_q;
    mepc_d     = mepc_q;
    sepc_d     = sepc_q;
    mscratch_d = mscratch_q;
    sscratch_d = sscratch_q;
    mcause_d   = mcause_q;
    scause_d   = scause_q;
    mtie_d     = mtie_q;
    priv_d     = priv_q;
    if (!stall) begin
      if (csr_trap_take) begin
        mepc_d                       = csr_trap_pc & ~32'd3;
        mcause_d                     = csr_cause;
        mstatus_d[MS_MPIE]           = mstatus_q[MS_MIE];
        mstatus_d[MS_MIE]            = 1'b0;
        mstatus_d[MS_MPP+1:MS_MPP]   = priv_q;
        priv_d                       = PRIV_M;
      end else if (csr_mret) begin
        priv_d                       = priv_e'(mstatus_q[MS_MPP+1:MS_MPP]);
        mstatus_d[MS_MIE]            = mstatus_q[MS_MPIE];
        mstatus_d[MS_MPIE]           = 1'b1;
        mstatus_d[MS_MPP+1:MS_MPP]   = 2'b00;
      end else if (csr_sret) begin
        priv_d                       = priv_e'({1'b0, mstatus_q[MS_SPP]});
        mstatus_d[MS_SIE]            = mstatus_q[MS_SPIE];
        mstatus_d[MS_SPIE]           = 1'b1;
        mstatus_d[MS_SPP]            = 1'b0;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus_d  = mstatus_legalize(wr_val);
          CSR_SSTATUS:  mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (wr_val & SSTATUS_MASK);
          CSR_MIE:      mtie_d     = wr_val[MIX_MT];
          CSR_MTVEC:    mtvec_d    = wr_val & ~32'd3;
          CSR_STVEC:    stvec_d    = wr_val & ~32'd3;
          CSR_MSCRATCH: mscratch_d = wr_val;
          CSR_SSCRATCH: sscratch_d = wr_val;
          CSR_MEPC:     mepc_d     = wr_val & ~32'd3;
          CSR_SEPC:     sepc_d     = wr_val & ~32'd3;
          CSR_MCAUSE:   mcause_d   = wr_val;
          CSR_SCAUSE:   scause_d   = wr_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      stvec_q    <= '0;
      mepc_q     <= '0;
      sepc_q     <= '0;
      mscratch_q <= '0;
      sscratch_q <= '0;
      mcause_q   <= '0;
      scause_q   <= '0;
      mtie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      priv_q     <= PRIV_M;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      stvec_q    <= stvec_d;
      mepc_q     <= mepc_d;
      sepc_q     <= sepc_d;
      mscratch_q <= mscratch_d;
      sscratch_q <= sscratch_d;
      mcause_q   <= mcause_d;
      scause_q   <= scause_d;
      mtie_q     <= mtie_d;
      mtip_q     <= irq_mtip;
      priv_q     <= priv_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_lo_i   (csr_we && (csr_addr == CSR_MCYCLE)),
    .ld_hi_i   (csr_we && (csr_addr == CSR_MCYCLEH)),
    .ld_data_i (wr_val),
    .count_o   (mcycle)
  );

  assign csr_rdata       = rdata;
  assign csr_trap_vector = {mtvec_q[31:2], 2'b00};
  assign csr_ret_addr    = csr_sret ? sepc_q : mepc_q;
  assign current_priv    = priv_q;
  assign irq_req         = mtip_q && mtie_q && ((priv_q != PRIV_M) || mstatus_q[MS_MIE]);

endmodule

// File: tb/tb_csr_unit.sv
// Directed and randomized bench for csr_unit against a field-level reference model.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write, csr_set, csr_clear;
  logic [31:0] csr_rdata;
  logic        csr_trap_take;
  logic [31:0] csr_trap_pc, csr_cause;
  logic        csr_mret, csr_sret;
  logic [31:0] csr_trap_vector, csr_ret_addr;
  logic [1:0]  current_priv;
  logic        irq_mtip;
  logic        irq_req;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one variable per architectural field.
  logic [1:0]  m_priv, m_mpp;
  logic        m_sie, m_mie, m_spie, m_mpie, m_spp, m_mtie, m_mtip;
  logic [31:0] m_mtvec, m_stvec, m_mepc, m_sepc, m_mscratch, m_sscratch, m_mcause, m_scause;
  logic [63:0] m_cycle;

  logic [31:0] rd_s, tv_s, ra_s;
  logic [1:0]  priv_s;
  logic        irq_s;
  logic [31:0] c0;

  logic [11:0] addrs [17] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                              12'h100, 12'h105, 12'h140, 12'h141, 12'h142, 12'hB00, 12'hB80,
                              12'hF14, 12'h7C0, 12'h301};

  csr_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear), .csr_rdata(csr_rdata),
    .csr_trap_take(csr_trap_take), .csr_trap_pc(csr_trap_pc), .csr_cause(csr_cause),
    .csr_mret(csr_mret), .csr_sret(csr_sret), .csr_trap_vector(csr_trap_vector),
    .csr_ret_addr(csr_ret_addr), .current_priv(current_priv), .irq_mtip(irq_mtip),
    .irq_req(irq_req)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_priv = 2'b11; m_mpp = 2'b00;
    m_sie = 0; m_mie = 0; m_spie = 0; m_mpie = 0; m_spp = 0; m_mtie = 0; m_mtip = 0;
    m_mtvec = 0; m_stvec = 0; m_mepc = 0; m_sepc = 0;
    m_mscratch = 0; m_sscratch = 0; m_mcause = 0; m_scause = 0;
    m_cycle = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] v;
    v = 0;
    case (a)
      12'h300: begin
        v[1] = m_sie; v[3] = m_mie; v[5] = m_spie; v[7] = m_mpie; v[8] = m_spp; v[12:11] = m_mpp;
      end
      12'h100: begin v[1] = m_sie; v[5] = m_spie; v[8] = m_spp; end
      12'h304: v[7] = m_mtie;
      12'h344: v[7] = m_mtip;
      12'h305: v = m_mtvec;
      12'h105: v = m_stvec;
      12'h340: v = m_mscratch;
      12'h140: v = m_sscratch;
      12'h341: v = m_mepc;
      12'h141: v = m_sepc;
      12'h342: v = m_mcause;
      12'h142: v = m_scause;
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin
        m_sie = v[1]; m_mie = v[3]; m_spie = v[5]; m_mpie = v[7]; m_spp = v[8];
        m_mpp = (v[12:11] == 2'b10) ? 2'b00 : v[12:11];
      end
      12'h100: begin m_sie = v[1]; m_spie = v[5]; m_spp = v[8]; end
      12'h304: m_mtie = v[7];
      12'h305: m_mtvec = {v[31:2], 2'b00};
      12'h105: m_stvec = {v[31:2], 2'b00};
      12'h340: m_mscratch = v;
      12'h140: m_sscratch = v;
      12'h341: m_mepc = {v[31:2], 2'b00};
      12'h141: m_sepc = {v[31:2], 2'b00};
      12'h342: m_mcause = v;
      12'h142: m_scause = v;
      default: ;
    endcase
  endtask

  task automatic model_update();
    logic [31:0] oldv, newv;
    logic        wr;
    if (!rst_n) begin
      m_reset();
      return;
    end
    wr = !stall && (csr_write || csr_set || csr_clear) && !csr_trap_take && !csr_mret && !csr_sret;
    oldv = m_read(csr_addr);
    newv = csr_write ? csr_wdata : (csr_set ? (oldv | csr_wdata) : (oldv & ~csr_wdata));
    if (wr && csr_addr == 12'hB00)      m_cycle[31:0] = newv;
    else if (wr && csr_addr == 12'hB80) m_cycle[63:32] = newv;
    else                                m_cycle = m_cycle + 64'd1;
    m_mtip = irq_mtip;
    if (stall) return;
    if (csr_trap_take) begin
      m_mepc = {csr_trap_pc[31:2], 2'b00};
      m_mcause = csr_cause;
      m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
    end else if (csr_mret) begin
      m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'b00;
    end else if (csr_sret) begin
      m_priv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1; m_spp = 0;
    end else if (wr) begin
      m_write(csr_addr, newv);
    end
  endtask

  task automatic idle();
    stall = 0; csr_write = 0; csr_set = 0; csr_clear = 0;
    csr_trap_take = 0; csr_mret = 0; csr_sret = 0;
  endtask

  // Sample outputs mid-cycle, compare with the model, then advance one edge.
  task automatic tick();
    logic irq_exp;
    @(negedge clk);
    rd_s = csr_rdata; tv_s = csr_trap_vector; ra_s = csr_ret_addr;
    priv_s = current_priv; irq_s = irq_req;
    irq_exp = m_mtip && m_mtie && ((m_priv != 2'b11) || m_mie);
    chk("rdata", rd_s, m_read(csr_addr));
    chk("priv", {30'd0, priv_s}, {30'd0, m_priv});
    chk("trap_vector", tv_s, m_mtvec);
    chk("ret_addr", ra_s, csr_sret ? m_sepc : m_mepc);
    chk("irq_req", {31'd0, irq_s}, {31'd0, irq_exp});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_op(input int kind, input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_addr = a; csr_wdata = d;
    csr_write = (kind == 1); csr_set = (kind == 2); csr_clear = (kind == 3);
    tick();
    idle();
  endtask

  task automatic peek(input logic [11:0] a);
    idle();
    csr_addr = a;
    tick();
  endtask

  initial begin
    rst_n = 0; irq_mtip = 0; csr_addr = 0; csr_wdata = 0; csr_trap_pc = 0; csr_cause = 0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    // Every address reads zero while reset is held.
    for (int i = 0; i < 17; i++) begin
      peek(addrs[i]);
      chk("reset_rdata", rd_s, 32'd0);
    end
    chk("reset_priv", {30'd0, priv_s}, 32'd3);
    chk("reset_vector", tv_s, 32'd0);
    chk("reset_irq", {31'd0, irq_s}, 32'd0);

    rst_n = 1;
    peek(12'h300); chk("mstatus_after_reset", rd_s, 32'd0);
    peek(12'h305); chk("mtvec_after_reset", rd_s, 32'd0);
    peek(12'hF14); chk("mhartid", rd_s, 32'd0);
    chk("priv_after_reset", {30'd0, priv_s}, 32'd3);

    // Trap entry through a direct-mode vector.
    do_op(1, 12'h305, 32'h0000_1003);
    idle();
    csr_trap_take = 1; csr_trap_pc = 32'h0000_0206; csr_cause = 32'h0000_000B;
    tick();
    chk("trap_vector_direct", tv_s, 32'h0000_1000);
    peek(12'h341); chk("trap_mepc", rd_s, 32'h0000_0204);
    peek(12'h342); chk("trap_mcause", rd_s, 32'h0000_000B);
    peek(12'h300); chk("trap_mstatus", rd_s, 32'h0000_1800);

    // mret back to U with MPIE restored into MIE.
    do_op(3, 12'h300, 32'h0000_1800);
    do_op(2, 12'h300, 32'h0000_0080);
    idle(); csr_mret = 1;
    tick();
    chk("mret_ret_addr", ra_s, 32'h0000_0204);
    peek(12'h300); chk("mret_mstatus", rd_s, 32'h0000_0088);
    chk("mret_priv", {30'd0, priv_s}, 32'd0);

    // Trap outranks a same-cycle CSR write.
    do_op(1, 12'h340, 32'h1111_1111);
    idle();
    csr_trap_take = 1; csr_trap_pc = 32'h0000_0300; csr_cause = 32'h0000_0002;
    csr_write = 1; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    tick();
    peek(12'h340); chk("trap_vs_write_mscratch", rd_s, 32'h1111_1111);
    peek(12'h341); chk("trap_vs_write_mepc", rd_s, 32'h0000_0300);
    chk("trap_vs_write_priv", {30'd0, priv_s}, 32'd3);

    // MPP=10 is written as 00; sstatus exposes only SIE/SPIE/SPP.
    do_op(1, 12'h300, 32'h0000_1000);
    peek(12'h300); chk("mpp_reserved", rd_s, 32'd0);
    do_op(1, 12'h100, 32'hFFFF_FFFF);
    peek(12'h300); chk("sstatus_view", rd_s, 32'h0000_0122);
    idle(); csr_sret = 1; csr_addr = 12'h141;
    tick();
    peek(12'h300); chk("sret_mstatus", rd_s, 32'h0000_0022);
    chk("sret_priv", {30'd0, priv_s}, 32'd1);

    // Stall freezes mepc/mcause but mcycle keeps counting.
    peek(12'hB00); c0 = rd_s;
    idle(); stall = 1; csr_write = 1; csr_addr = 12'h341; csr_wdata = 32'h5555_5554;
    csr_trap_take = 1; csr_trap_pc = 32'h0000_0800; csr_cause = 32'h0000_0009;
    tick();
    csr_trap_take = 0;
    tick();
    csr_addr = 12'hB00; csr_wdata = 32'd0;
    tick();
    peek(12'hB00); chk("stall_mcycle", rd_s, c0 + 32'd4);
    peek(12'h341); chk("stall_mepc", rd_s, 32'h0000_0300);
    peek(12'h342); chk("stall_mcause", rd_s, 32'h0000_0002);

    // mcycle wrap, then timer interrupt at U.
    do_op(3, 12'h300, 32'h0000_1800);
    idle(); csr_mret = 1; tick();
    do_op(1, 12'h304, 32'h0000_0080);
    do_op(1, 12'hB00, 32'hFFFF_FFFF);
    do_op(1, 12'hB80, 32'hFFFF_FFFF);
    peek(12'hB80); chk("mcycleh_full", rd_s, 32'hFFFF_FFFF);
    peek(12'hB00); chk("mcycle_wrap_lo", rd_s, 32'd0);
    peek(12'hB80); chk("mcycle_wrap_hi", rd_s, 32'd0);
    irq_mtip = 1;
    peek(12'h344); chk("irq_not_yet", {31'd0, irq_s}, 32'd0);
    peek(12'h344); chk("irq_asserted", {31'd0, irq_s}, 32'd1);
    chk("mip_mtip", rd_s, 32'h0000_0080);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      idle();
      rst_n = ($urandom_range(0, 149) != 0);
      stall = ($urandom_range(0, 4) == 0);
      irq_mtip = 1'($urandom_range(0, 1));
      csr_addr = addrs[$urandom_range(0, 16)];
      csr_wdata = $urandom();
      csr_trap_pc = $urandom();
      csr_cause = $urandom();
      sel = $urandom_range(0, 3);
      csr_write = (sel == 1); csr_set = (sel == 2); csr_clear = (sel == 3);
      sel = $urandom_range(0, 19);
      csr_trap_take = (sel == 0); csr_mret = (sel == 1); csr_sret = (sel == 2);
      tick();
    end
    rst_n = 1;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
